// File: rtl/alu_muldiv_sequencer_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the multiply/divide unit.
package alu_muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } md_state_e;

  function automatic logic op_is_signed(md_op_e o);
    return (o == MD_MULT) || (o == MD_DIV);
  endfunction

  function automatic logic op_is_div(md_op_e o);
    return (o == MD_DIV) || (o == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// Combinational add/sub for one shift-add / restoring-divide step; borrow is the bit
// above the result and is only meaningful for subtraction.
module muldiv_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         borrow
);

  logic [W:0] full;

  // Widen by one bit so the borrow out of the top lands in full[W]
  always_comb begin
    full   = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    sum    = full[W-1:0];
    borrow = sub & full[W];
  end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: sign-magnitude prep, WIDTH add/sub steps,
// sign fix-up, then a one-cycle done pulse with hi/lo held until the next result.
module alu_muldiv_sequencer
  import alu_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state_q, state_d;
  md_op_e             op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   m_q;          // |a| for multiply, |b| for divide
  logic [WIDTH-1:0]   w_hi_q;       // product high / partial remainder
  logic [WIDTH-1:0]   w_lo_q;       // product low / quotient
  logic [WIDTH-1:0]   res_hi_q, res_lo_q;
  logic               sign_a_q, sign_b_q, dz_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept, sgn, is_div, b_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_x, add_y, add_sum, mul_c_hi;
  logic               add_borrow;
  logic [WIDTH-1:0]   step_hi, step_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_neg;

  assign accept = start && !flush && (state_q == IDLE || state_q == DONE);
  assign sgn    = op_is_signed(op_q);
  assign is_div = op_is_div(op_q);
  assign b_zero = (b_q == '0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; flush overrides every transition including an accept
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = PREP;
      PREP:    state_d = (is_div && b_zero) ? DONE : ITER;
      ITER:    if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = start ? PREP : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // FSM outputs
  always_comb begin
    busy     = (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
    done     = (state_q == DONE);
    div_zero = dz_q;
    hi       = res_hi_q;
    lo       = res_lo_q;
  end

  muldiv_addsub #(.W(WIDTH + 1)) u_addsub (
    .x      (add_x),
    .y      (add_y),
    .sub    (is_div),
    .sum    (add_sum),
    .borrow (add_borrow)
  );

  // Datapath combinational: magnitudes, one iteration step, and sign fix-up
  always_comb begin
    abs_a    = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
    abs_b    = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
    add_x    = is_div ? {w_hi_q, w_lo_q[WIDTH-1]} : {1'b0, w_hi_q};
    add_y    = {1'b0, m_q};
    mul_c_hi = w_lo_q[0] ? add_sum : {1'b0, w_hi_q};
    if (is_div) begin
      step_hi = add_borrow ? add_x[WIDTH-1:0] : add_sum[WIDTH-1:0];
      step_lo = {w_lo_q[WIDTH-2:0], ~add_borrow};
    end else begin
      step_hi = mul_c_hi[WIDTH:1];
      step_lo = {mul_c_hi[0], w_lo_q[WIDTH-1:1]};
    end
    prod_neg = -{w_hi_q, w_lo_q};
    fix_hi   = w_hi_q;
    fix_lo   = w_lo_q;
    unique case (op_q)
      MD_MULT: if (sign_a_q ^ sign_b_q) {fix_hi, fix_lo} = prod_neg;
      MD_DIV: begin
        if (sign_a_q ^ sign_b_q) fix_lo = -w_lo_q;
        if (sign_a_q)            fix_hi = -w_hi_q;
      end
      default: ;
    endcase
  end

  // Datapath registers; result registers change only on a completed (unflushed) op
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= MD_MULT;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      w_hi_q   <= '0;
      w_lo_q   <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        op_q <= md_op_e'(op);
        a_q  <= a;
        b_q  <= b;
      end
      unique case (state_q)
        PREP: begin
          sign_a_q <= sgn & a_q[WIDTH-1];
          sign_b_q <= sgn & b_q[WIDTH-1];
          cnt_q    <= CNT_W'(WIDTH);
          w_hi_q   <= '0;
          w_lo_q   <= is_div ? abs_a : abs_b;
          m_q      <= is_div ? abs_b : abs_a;
          if (is_div && b_zero && !flush) begin
            res_hi_q <= a_q;
            res_lo_q <= '1;
            dz_q     <= 1'b1;
          end
        end
        ITER: begin
          cnt_q  <= cnt_q - CNT_W'(1);
          w_hi_q <= step_hi;
          w_lo_q <= step_lo;
        end
        FIX: begin
          if (!flush) begin
            res_hi_q <= fix_hi;
            res_lo_q <= fix_lo;
            dz_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer with an expected-result queue.
module tb_alu_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  logic [31:0] prev_hi, prev_lo;

  alu_muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, optionally poke a start while busy, then check the popped expectation.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input int elat, input int poke);
    exp_t e;
    int   cyc;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    e.tag = tag; e.hi = eh; e.lo = el; e.dz = edz; e.lat = elat;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy_after_accept"}, busy, 1);
    while (done !== 1'b1 && cyc < 100) begin
      if (cyc == poke) begin
        start = 1'b1; op = 2'b11; a = 32'h9; b = 32'h0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, cyc, elat);
    chk({tag, "_busy_at_done"}, busy, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_hi"}, hi, e.hi);
      chk({e.tag, "_lo"}, lo, e.lo);
      chk({e.tag, "_div_zero"}, div_zero, e.dz);
      prev_hi = e.hi;
      prev_lo = e.lo;
    end
  endtask

  task automatic expect_no_done(input string tag, input int ncyc);
    int seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
    prev_hi = '0; prev_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_div_zero", div_zero, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, 0);
    @(posedge clk); #1;
    chk("done_pulse_falls", done, 0);
    chk("hold_hi_idle", hi, prev_hi);

    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35, 0);
    run_op("div_neg7by2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, 0);
    run_op("div_7byneg2", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 35, 0);
    run_op("divu_100by7", 2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 35, 0);
    run_op("divu_by_zero", 2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 2, 0);
    run_op("div_min_by_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35, 0);
    // Called straight from the DONE cycle: accept from DONE, busy checked in the next cycle
    run_op("b2b_mult_m1x5", 2'b00, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 35, 0);

    // flush together with start in DONE: start is dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'h3; b = 32'h3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", busy, 0);
    chk("flush_start_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("flush_start_dropped", busy, 0);
    chk("flush_start_hi", hi, prev_hi);

    // flush in the 10th ITER cycle (cycle 11)
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'h1234; b = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_hi_kept", hi, prev_hi);
    chk("flush_lo_kept", lo, prev_lo);
    expect_no_done("flush_no_done", 40);

    run_op("multu_6x7", 2'b01, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b0, 35, 0);
    run_op("start_while_busy", 2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0, 35, 5);

    // reset in the middle of an op
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'h0000_0100; b = 32'h0000_0003;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_div_zero", div_zero, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_no_done("midrst_no_done", 40);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
